// File: rtl/reg_read.sv
// reg_read: reads a chain of 74HC165 parallel-in/serial-out shift registers.
//
// One request on i_START pulses o_PL_N low to capture the chain's parallel
// inputs. It then clocks WIDTH bits out on o_CP and presents the word on
// o_DATA, with a one-cycle o_VALID pulse.
//
// Parameters
//   WIDTH  number of bits in the chain
//   DIV    system clocks per o_CP half-period and per load pulse (>= 1)
//
// Ports
//   i_CLK     system clock, rising edge
//   i_RST_N   asynchronous active-low reset
//   i_START   read request, only looked at while idle
//   i_Q7      serial data from the last register in the chain
//   o_PL_N    parallel-load strobe, active low
//   o_CP      shift clock; the chain shifts on its rising edge
//   o_DATA    last completed read, MSB = first bit received
//   o_VALID   one-cycle pulse when o_DATA updates
//   o_BUSY    high while a read is in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_START; counters held at their reload values
// LOAD  | o_PL_N low for DIV cycles
// SHIFT | WIDTH bit periods, DIV cycles o_CP low then DIV cycles high
// DONE  | one cycle; publish the shifted word and pulse o_VALID
//
// Every output is a flop fed from the current state. All outputs therefore
// trail the state by one cycle. This is where the "+1" in the
// start-to-valid latency comes from.

module reg_read #(
    parameter int WIDTH = 24,
    parameter int DIV   = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_START,
    input  logic             i_Q7,
    output logic             o_PL_N,
    output logic             o_CP,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_VALID,
    output logic             o_BUSY
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int PH_W  = $clog2(DIV + 1);

    localparam logic [PH_W-1:0]  PH_RELOAD  = PH_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_RELOAD = BIT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PH_W-1:0]   phase_q;   // cycles left in the current half-period, down to 0
    logic              half_q;    // 0 = o_CP low half of the bit, 1 = high half
    logic [BIT_W-1:0]  bits_q;    // bit periods still to run
    logic [WIDTH-1:0]  shreg_q;

    logic              phase_tc;
    logic              last_bit;

    logic              pl_n_d;
    logic              cp_d;
    logic              valid_d;
    logic              busy_d;

    assign phase_tc = (phase_q == '0);
    assign last_bit = (bits_q == BIT_W'(1));

    // State register
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (i_START) state_d = S_LOAD;
            S_LOAD:  if (phase_tc) state_d = S_SHIFT;
            S_SHIFT: if (phase_tc && half_q && last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        pl_n_d  = (state_q != S_LOAD);
        cp_d    = (state_q == S_SHIFT) && half_q;
        valid_d = (state_q == S_DONE);
        busy_d  = (state_q != S_IDLE);
    end

    // Phase and bit timers. Idle and done keep them parked at reload values,
    // so LOAD always starts with a full phase count.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            phase_q <= '0;
            half_q  <= 1'b0;
            bits_q  <= '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    half_q <= 1'b0;
                    bits_q <= BIT_RELOAD;
                    if (phase_tc) phase_q <= PH_RELOAD;
                    else          phase_q <= phase_q - 1'b1;
                end
                S_SHIFT: begin
                    if (phase_tc) begin
                        phase_q <= PH_RELOAD;
                        half_q  <= ~half_q;
                        if (half_q) bits_q <= bits_q - 1'b1;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                default: begin
                    phase_q <= PH_RELOAD;
                    half_q  <= 1'b0;
                    bits_q  <= BIT_RELOAD;
                end
            endcase
        end
    end

    // Output flops and data capture. Sampling happens on the edge that
    // raises o_CP (cp_d high, o_CP still low). i_Q7 still shows the bit
    // from before that shift.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_PL_N  <= 1'b1;
            o_CP    <= 1'b0;
            o_VALID <= 1'b0;
            o_BUSY  <= 1'b0;
            o_DATA  <= '0;
            shreg_q <= '0;
        end else begin
            o_PL_N  <= pl_n_d;
            o_CP    <= cp_d;
            o_VALID <= valid_d;
            o_BUSY  <= busy_d;
            if (cp_d && !o_CP) shreg_q <= (shreg_q << 1) | WIDTH'(i_Q7);
            if (valid_d)       o_DATA  <= shreg_q;
        end
    end

endmodule

// File: tb/tb_reg_read.sv
// Bench for reg_read with three instances:
//   A = WIDTH 24 DIV 1, B = WIDTH 24 DIV 3, C = WIDTH 8 DIV 1.
// Each instance drives its own 74HC165 chain model. The reference model
// works purely in transaction time. Once a start is accepted, the outputs
// at cycle k after the start edge follow directly from DIV and WIDTH.
module tb_reg_read;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v   = 3'b111;
    logic [2:0] start_v = 3'b000;
    logic [2:0] pl_n_v, cp_v, valid_v, busy_v, q7_v;

    logic pl_n_a, cp_a, valid_a, busy_a;
    logic pl_n_b, cp_b, valid_b, busy_b;
    logic pl_n_c, cp_c, valid_c, busy_c;
    logic [23:0] data_a, data_b;
    logic [7:0]  data_c;
    logic [23:0] dat_v [3];
    logic [23:0] pre [3];

    logic [23:0] chain_a = '0;
    logic [23:0] chain_b = '0;
    logic [7:0]  chain_c = '0;

    int div_v [3] = '{1, 3, 1};
    int w_v   [3] = '{24, 24, 8};

    int checks = 0;
    int fails  = 0;
    int n      = 0;

    // model state
    bit          act   [3] = '{0, 0, 0};
    int          t0    [3] = '{0, 0, 0};
    logic [23:0] cap   [3] = '{24'h0, 24'h0, 24'h0};
    logic [23:0] edata [3] = '{24'h0, 24'h0, 24'h0};

    // monitors
    int pl_cnt [3], cp_cnt [3], cp_rise_t [3], cp_period [3];
    int vcnt [3], brise [3], blow [3], bhigh [3];
    logic cp_prev [3], busy_prev [3];

    assign pl_n_v  = {pl_n_c, pl_n_b, pl_n_a};
    assign cp_v    = {cp_c, cp_b, cp_a};
    assign valid_v = {valid_c, valid_b, valid_a};
    assign busy_v  = {busy_c, busy_b, busy_a};
    assign q7_v    = {chain_c[7], chain_b[23], chain_a[23]};
    assign dat_v[0] = data_a;
    assign dat_v[1] = data_b;
    assign dat_v[2] = {16'h0, data_c};

    reg_read #(.WIDTH(24), .DIV(1)) u_a (
        .i_CLK(clk), .i_RST_N(rst_v[0]), .i_START(start_v[0]), .i_Q7(q7_v[0]),
        .o_PL_N(pl_n_a), .o_CP(cp_a), .o_DATA(data_a), .o_VALID(valid_a), .o_BUSY(busy_a)
    );
    reg_read #(.WIDTH(24), .DIV(3)) u_b (
        .i_CLK(clk), .i_RST_N(rst_v[1]), .i_START(start_v[1]), .i_Q7(q7_v[1]),
        .o_PL_N(pl_n_b), .o_CP(cp_b), .o_DATA(data_b), .o_VALID(valid_b), .o_BUSY(busy_b)
    );
    reg_read #(.WIDTH(8), .DIV(1)) u_c (
        .i_CLK(clk), .i_RST_N(rst_v[2]), .i_START(start_v[2]), .i_Q7(q7_v[2]),
        .o_PL_N(pl_n_c), .o_CP(cp_c), .o_DATA(data_c), .o_VALID(valid_c), .o_BUSY(busy_c)
    );

    // 74HC165 chains: load on PL_N falling, shift toward Q7 on CP rising
    always @(negedge pl_n_a or posedge cp_a)
        if (!pl_n_a) chain_a <= pre[0]; else chain_a <= {chain_a[22:0], 1'b0};
    always @(negedge pl_n_b or posedge cp_b)
        if (!pl_n_b) chain_b <= pre[1]; else chain_b <= {chain_b[22:0], 1'b0};
    always @(negedge pl_n_c or posedge cp_c)
        if (!pl_n_c) chain_c <= pre[2][7:0]; else chain_c <= {chain_c[6:0], 1'b0};

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act_v, exp_v, $time);
        end
    endtask

    function automatic int lat(input int i);
        return div_v[i] * (1 + 2 * w_v[i]) + 1;
    endfunction

    // Expected outputs k cycles after the start edge (k<1 means idle)
    function automatic void exp_out(input int k, input int dv, input int w,
                                    output logic pl, output logic cp,
                                    output logic bz, output logic vd);
        int l, j;
        l  = dv * (1 + 2 * w) + 1;
        pl = 1'b1; cp = 1'b0; bz = 1'b0; vd = 1'b0;
        if (k >= 1 && k <= l) begin
            bz = 1'b1;
            pl = !(k <= dv);
            j  = k - 1 - dv;
            cp = (j >= 0) && (j < 2 * dv * w) && ((j % (2 * dv)) >= dv);
            vd = (k == l);
        end
    endfunction

    // Model update and per-cycle compare
    always @(posedge clk) begin
        int k;
        logic epl, ecp, ebz, evd;
        n = n + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rst_v[i]) begin
                act[i]   = 0;
                edata[i] = '0;
            end else if (start_v[i] && (!act[i] || (n - t0[i]) > lat(i))) begin
                act[i] = 1;
                t0[i]  = n;
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            k = act[i] ? (n - t0[i]) : -1;
            exp_out(k, div_v[i], w_v[i], epl, ecp, ebz, evd);
            if (k == 1) cap[i] = pre[i];
            if (evd)    edata[i] = cap[i];
            chk($sformatf("pl_n%0d", i),  pl_n_v[i],  epl);
            chk($sformatf("cp%0d", i),    cp_v[i],    ecp);
            chk($sformatf("busy%0d", i),  busy_v[i],  ebz);
            chk($sformatf("valid%0d", i), valid_v[i], evd);
            chk($sformatf("data%0d", i),  dat_v[i],   edata[i]);
            if (!pl_n_v[i]) pl_cnt[i]++;
            if (cp_v[i] && !cp_prev[i]) begin
                cp_cnt[i]++;
                cp_period[i] = n - cp_rise_t[i];
                cp_rise_t[i] = n;
            end
            cp_prev[i] = cp_v[i];
            if (valid_v[i]) vcnt[i]++;
            if (busy_v[i] && !busy_prev[i]) brise[i]++;
            if (!busy_v[i]) blow[i]++; else bhigh[i]++;
            busy_prev[i] = busy_v[i];
        end
    end

    task automatic wait_valid(input int i, input int budget, output int tv, output bit ok);
        ok = 0;
        tv = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #2;
            if (valid_v[i]) begin
                ok = 1;
                tv = n;
                break;
            end
        end
        if (!ok) chk($sformatf("timeout%0d", i), 0, 1);
    endtask

    task automatic start_pulse(input int i, input logic [23:0] val, output int t);
        @(negedge clk);
        pre[i] = val;
        start_v[i] = 1'b1;
        @(posedge clk); #2;
        t = n;
        pl_cnt[i] = 0; cp_cnt[i] = 0; vcnt[i] = 0;
        brise[i] = 0; bhigh[i] = 0; blow[i] = 0;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic run_one(input int i, input logic [23:0] val, input int elat,
                           input int epl, input int ecp, input string nm);
        int t, tv;
        bit ok;
        start_pulse(i, val, t);
        wait_valid(i, elat + 50, tv, ok);
        if (ok) begin
            chk({nm, "_latency"}, tv - t, elat);
            chk({nm, "_data"},    dat_v[i], val);
            chk({nm, "_pl_low"},  pl_cnt[i], epl);
            chk({nm, "_cp_cnt"},  cp_cnt[i], ecp);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int t, tv1, tv2;
        bit ok1, ok2;
        for (int i = 0; i < 3; i++) begin
            pre[i] = '0; pl_cnt[i] = 0; cp_cnt[i] = 0; cp_rise_t[i] = 0; cp_period[i] = 0;
            vcnt[i] = 0; brise[i] = 0; blow[i] = 0; bhigh[i] = 0;
            cp_prev[i] = 1'b0; busy_prev[i] = 1'b0;
        end
        #1 rst_v = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_pl_n%0d", i),  pl_n_v[i],  1'b1);
            chk($sformatf("rst_cp%0d", i),    cp_v[i],    1'b0);
            chk($sformatf("rst_busy%0d", i),  busy_v[i],  1'b0);
            chk($sformatf("rst_valid%0d", i), valid_v[i], 1'b0);
            chk($sformatf("rst_data%0d", i),  dat_v[i],   24'h0);
        end
        repeat (3) @(negedge clk);
        rst_v = 3'b111;
        repeat (2) @(posedge clk);

        // single read, DIV 1
        run_one(0, 24'hA5C3F0, 50, 1, 24, "a_basic");

        // DIV 3: 3-cycle load pulse, 6-cycle CP period
        run_one(1, 24'h000001, 148, 3, 24, "b_div3");
        chk("b_cp_period", cp_period[1], 6);

        // WIDTH 8
        run_one(2, 24'h00005A, 18, 1, 8, "c_w8");

        // start pulses during SHIFT and during DONE are ignored
        start_pulse(0, 24'h35A1C7, t);
        while (n < t + 10) begin @(posedge clk); #2; end
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        while (n < t + 49) begin @(posedge clk); #2; end
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        chk("ign_valid_cnt", vcnt[0], 1);
        chk("ign_busy_rise", brise[0], 1);
        chk("ign_busy_len",  bhigh[0], 50);
        chk("ign_data",      dat_v[0], 24'h35A1C7);

        // start held high: back-to-back reads
        @(negedge clk);
        pre[0] = 24'hFFFFFF;
        start_v[0] = 1'b1;
        wait_valid(0, 120, tv1, ok1);
        if (ok1) begin
            chk("b2b_data1", dat_v[0], 24'hFFFFFF);
            blow[0] = 0;
            @(negedge clk);
            pre[0] = 24'h800000;
            wait_valid(0, 120, tv2, ok2);
            if (ok2) begin
                chk("b2b_spacing", tv2 - tv1, 51);
                chk("b2b_data2",   dat_v[0], 24'h800000);
                chk("b2b_idle",    blow[0], 1);
            end
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (60) @(posedge clk);

        // reset in the middle of SHIFT (bit 10)
        start_pulse(0, 24'h123456, t);
        while (n < t + 22) begin @(posedge clk); #2; end
        chk("mid_busy_before", busy_v[0], 1'b1);
        #1 rst_v[0] = 1'b0;
        #1;
        chk("mid_rst_pl_n",  pl_n_v[0],  1'b1);
        chk("mid_rst_cp",    cp_v[0],    1'b0);
        chk("mid_rst_busy",  busy_v[0],  1'b0);
        chk("mid_rst_valid", valid_v[0], 1'b0);
        chk("mid_rst_data",  dat_v[0],   24'h0);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        chk("mid_no_valid", vcnt[0], 0);
        chk("mid_data_zero", dat_v[0], 24'h0);
        run_one(0, 24'h3C0F96, 50, 1, 24, "a_after_rst");

        // randomized traffic on all three instances
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                if (!busy_v[i]) pre[i] = (i == 2) ? ($urandom & 24'hFF) : 24'($urandom);
            end
            if (!rst_v[0]) rst_v[0] = 1'b1;
            else if ($urandom_range(0, 249) == 0) rst_v[0] = 1'b0;
        end
        @(negedge clk);
        start_v = 3'b000;
        rst_v   = 3'b111;
        repeat (200) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/reg_read.md
REG_READ -- requirements
Module: reg_read

Interface
REQ-001 The module SHALL have parameter WIDTH, default 24, giving the number of bits read from the chained 74HC165 parallel-in/serial-out registers.
REQ-002 The module SHALL have parameter DIV, default 1, giving the system-clock cycles per half-period of o_CP and the length of the load pulse; the legal range is DIV >= 1.
REQ-003 i_CLK  input  1  system clock; all flops are clocked on the rising edge.
REQ-004 i_RST_N  input  1  asynchronous, active-low reset.
REQ-005 i_START  input  1  request one read transaction; sampled only in IDLE.
REQ-006 i_Q7  input  1  serial data from the last 74HC165 in the chain.
REQ-007 o_PL_N  output  1  parallel-load strobe to the 74HC165 chain, active low.
REQ-008 o_CP  output  1  shift clock to the 74HC165 chain; the chain shifts on the rising edge.
REQ-009 o_DATA  output  WIDTH  last completed read, MSB = first bit received.
REQ-010 o_VALID  output  1  one-cycle pulse when o_DATA has been updated.
REQ-011 o_BUSY  output  1  high while a transaction is in progress.
REQ-012 All outputs SHALL be driven from registers.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-014 IDLE SHALL move to LOAD on the edge where i_START=1, and otherwise SHALL remain in IDLE.
REQ-015 LOAD SHALL hold o_PL_N=0 and o_CP=0 for exactly DIV cycles, then move to SHIFT with o_PL_N=1.
REQ-016 SHIFT SHALL run WIDTH bit periods, each of DIV cycles with o_CP=0 followed by DIV cycles with o_CP=1.
REQ-017 In each bit period, i_Q7 SHALL be sampled on the clock edge that ends the o_CP-low phase, i.e. before the o_CP rising edge.
REQ-018 Sampled bits SHALL shift into an internal WIDTH-bit register MSB-first, so the first bit lands in bit WIDTH-1 and the last in bit 0.
REQ-019 The bit counter SHALL be clog2(WIDTH+1) bits wide and the phase counter clog2(DIV+1) bits wide; neither SHALL wrap in normal operation.
REQ-020 SHIFT SHALL move to DONE after the o_CP-high phase of bit WIDTH-1, leaving o_CP=0.
REQ-021 DONE SHALL last one cycle, copy the internal register to o_DATA, assert o_VALID for that cycle, then move to IDLE.
REQ-022 o_BUSY SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-023 o_VALID SHALL rise DIV*(1+2*WIDTH)+1 cycles after the edge that sampled i_START.
REQ-024 i_START SHALL be ignored while o_BUSY=1, including in the DONE cycle; a request held high re-triggers on the first IDLE cycle.
REQ-025 o_DATA SHALL hold its value between transactions and change only in DONE.
REQ-026 With i_START held high continuously, back-to-back transactions SHALL be separated by exactly one IDLE cycle.

Reset
REQ-027 i_RST_N=0 SHALL immediately force state=IDLE, o_PL_N=1, o_CP=0, o_DATA=0, o_VALID=0, o_BUSY=0, and clear all counters and the internal register.
REQ-028 A reset asserted mid-transaction SHALL abort it with no o_VALID pulse, leaving o_DATA=0.
REQ-029 After reset release, the module SHALL wait in IDLE for i_START.

Verification
REQ-030 Bench SHALL cover: WIDTH=24, DIV=1, 74HC165 chain model preloaded 24'hA5C3F0, single-cycle i_START -> one 1-cycle o_PL_N low pulse, 24 o_CP pulses, o_VALID 50 cycles after the start edge, o_DATA=24'hA5C3F0.
REQ-031 Bench SHALL cover: DIV=3, chain preloaded 24'h000001 -> o_PL_N low 3 cycles, o_CP period 6 cycles, o_VALID 148 cycles after the start edge, o_DATA=24'h000001.
REQ-032 Bench SHALL cover: i_START pulsed again during SHIFT and during DONE -> ignored, exactly one o_VALID, o_BUSY continuous.
REQ-033 Bench SHALL cover: i_START held high, chain values 24'hFFFFFF then 24'h800000 -> two o_VALID pulses 51 cycles apart with o_DATA as loaded, one IDLE cycle between transactions.
REQ-034 Bench SHALL cover: i_RST_N low at bit 10 of SHIFT -> outputs go to reset values asynchronously, no o_VALID, o_DATA=0; the next i_START completes normally.
REQ-035 Bench SHALL cover: WIDTH=8, DIV=1, chain 8'h5A -> o_VALID 18 cycles after the start edge, o_DATA=8'h5A.
